// File: rtl/dco_trim_pkg.sv
// Shared definitions for the DCO trim ramp controller and other trim sources.
package dco_trim_pkg;

  // Default geometry of the digital_pll external trim bus
  localparam int DEF_TRIM_W  = 26;
  localparam int DEF_LEVEL_W = 5;

  // Controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } trim_state_t;

  // Thermometer code for a level: the lowest 'lvl' bits set, i.e. (1<<lvl)-1
  function automatic logic [DEF_TRIM_W-1:0] therm(input logic [DEF_LEVEL_W-1:0] lvl);
    logic [DEF_TRIM_W-1:0] t;
    t = '0;
    for (int i = 0; i < DEF_TRIM_W; i++) begin
      t[i] = (32'(lvl) > i);
    end
    return t;
  endfunction

endpackage

// File: rtl/trim_therm_enc.sv
// Level to thermometer decode for the digital_pll ext_trim bus.
// Bit i is set whenever the level exceeds i, so ext_trim = (1<<level)-1.
module trim_therm_enc #(
  parameter int TRIM_W  = 26,
  parameter int LEVEL_W = 5
) (
  input  logic [LEVEL_W-1:0] level,
  output logic [TRIM_W-1:0]  ext_trim
);

  genvar gi;
  generate
    for (gi = 0; gi < TRIM_W; gi++) begin : g_therm
      assign ext_trim[gi] = (level > LEVEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/dco_trim_ramp.sv
// DCO trim ramp controller: accepts a target trim level, walks ext_trim one
// unit code at a time toward it, waits for the oscillator to settle and then
// pulses done. A release request ramps to zero and hands control back to the FLL.
module dco_trim_ramp
  import dco_trim_pkg::*;
#(
  parameter int TRIM_W        = DEF_TRIM_W,
  parameter int LEVEL_W       = DEF_LEVEL_W,
  parameter int STEP_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic               osc,
  input  logic               resetb,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [LEVEL_W-1:0] req_code,
  input  logic               req_mode,
  output logic               dco,
  output logic [TRIM_W-1:0]  ext_trim,
  output logic [LEVEL_W-1:0] level,
  output logic               busy,
  output logic               done
);

  // One counter serves both the per-level dwell and the final settle wait
  localparam int MAX_CYC = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]   STEP_RELOAD   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX     = LEVEL_W'(TRIM_W);

  trim_state_t        state_reg;
  logic [LEVEL_W-1:0] level_reg;
  logic [LEVEL_W-1:0] target_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               mode_reg;
  logic               dco_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [LEVEL_W-1:0] req_target;
  logic [LEVEL_W-1:0] level_next;

  // Requested target (clamped, or zero for a release) and the next ramp level
  always_comb begin
    req_target = '0;
    if (req_mode) begin
      req_target = (req_code > LEVEL_MAX) ? LEVEL_MAX : req_code;
    end
    level_next = (target_reg > level_reg) ? level_reg + 1'b1 : level_reg - 1'b1;
  end

  // Handshake FSM with level, target, counter and registered status outputs
  always_ff @(posedge osc or negedge resetb) begin
    if (!resetb) begin
      state_reg  <= IDLE;
      level_reg  <= '0;
      target_reg <= '0;
      cnt_reg    <= '0;
      mode_reg   <= 1'b0;
      dco_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            target_reg <= req_target;
            mode_reg   <= req_mode;
            busy_reg   <= 1'b1;
            // Taking control asserts dco before the first trim step;
            // a release keeps dco as it is until the ramp has finished
            if (req_mode) begin
              dco_reg <= 1'b1;
            end
            if (req_target != level_reg) begin
              state_reg <= RAMP;
              cnt_reg   <= STEP_RELOAD;
            end else begin
              state_reg <= SETTLE;
              cnt_reg   <= SETTLE_RELOAD;
            end
          end
        end
        RAMP: begin
          if (cnt_reg == '0) begin
            level_reg <= level_next;
            if (level_next == target_reg) begin
              state_reg <= SETTLE;
              cnt_reg   <= SETTLE_RELOAD;
            end else begin
              cnt_reg <= STEP_RELOAD;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            if (!mode_reg) begin
              dco_reg <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Thermometer decode of the applied level
  trim_therm_enc #(
    .TRIM_W  (TRIM_W),
    .LEVEL_W (LEVEL_W)
  ) u_therm (
    .level    (level_reg),
    .ext_trim (ext_trim)
  );

  assign req_ready = (state_reg == IDLE);
  assign dco       = dco_reg;
  assign level     = level_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_dco_trim_ramp.sv
// Directed bench for dco_trim_ramp with STEP_CYCLES=16, SETTLE_CYCLES=64.
module tb_dco_trim_ramp;

  localparam int TRIM_W  = 26;
  localparam int LEVEL_W = 5;
  localparam int STEP    = 16;
  localparam int SETTLE  = 64;

  logic               osc;
  logic               resetb;
  logic               req_valid;
  logic               req_ready;
  logic [LEVEL_W-1:0] req_code;
  logic               req_mode;
  logic               dco;
  logic [TRIM_W-1:0]  ext_trim;
  logic [LEVEL_W-1:0] level;
  logic               busy;
  logic               done;

  int n_checks;
  int n_errors;
  logic exp_dco;

  dco_trim_ramp #(
    .TRIM_W        (TRIM_W),
    .LEVEL_W       (LEVEL_W),
    .STEP_CYCLES   (STEP),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .osc       (osc),
    .resetb    (resetb),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_code  (req_code),
    .req_mode  (req_mode),
    .dco       (dco),
    .ext_trim  (ext_trim),
    .level     (level),
    .busy      (busy),
    .done      (done)
  );

  initial osc = 1'b0;
  always #10 osc = ~osc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one posedge and settle past it
  task automatic tick();
    @(posedge osc);
    #1;
  endtask

  function automatic logic [31:0] therm_exp(input int lvl);
    logic [31:0] t;
    t = (32'd1 << lvl) - 32'd1;
    return t;
  endfunction

  // Issue one request and follow it to the done pulse, checking every level step.
  // With hold=1 req_valid stays high carrying hold_code during the whole transaction.
  task automatic run_req(input logic mode, input int code, input int start, input int target,
                         input logic hold, input int hold_code);
    int cur;
    req_valid = 1'b1;
    req_code  = LEVEL_W'(code);
    req_mode  = mode;
    tick();
    if (mode) exp_dco = 1'b1;
    if (hold) req_code = LEVEL_W'(hold_code);
    else      req_valid = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_ready", req_ready, 0);
    check("accept_done", done, 0);
    check("accept_dco", dco, exp_dco);
    check("accept_level", level, start);
    cur = start;
    while (cur != target) begin
      repeat (STEP - 1) tick();
      check("dwell_level", level, cur);
      cur = (target > cur) ? cur + 1 : cur - 1;
      tick();
      check("step_level", level, cur);
      check("step_trim", ext_trim, therm_exp(cur));
      check("step_dco", dco, exp_dco);
      if (hold) check("hold_ready", req_ready, 0);
    end
    repeat (SETTLE - 1) tick();
    check("settle_busy", busy, 1);
    check("settle_done", done, 0);
    check("settle_dco", dco, exp_dco);
    tick();
    if (!mode) exp_dco = 1'b0;
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_ready", req_ready, 1);
    check("done_dco", dco, exp_dco);
    check("done_level", level, target);
    $display("txn mode=%0d code=%0d: level %0d -> %0d, dco=%0d", mode, code, start, target, dco);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_dco   = 1'b0;
    resetb    = 1'b0;
    req_valid = 1'b0;
    req_code  = '0;
    req_mode  = 1'b0;

    // 1. Reset
    #40;
    check("rst_dco", dco, 0);
    check("rst_trim", ext_trim, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #15 resetb = 1'b1;
    tick();
    check("rst_ready", req_ready, 1);
    $display("txn reset: ready=%0d level=%0d", req_ready, level);

    // 2. Take control at level 8
    run_req(1'b1, 8, 0, 8, 1'b0, 0);
    check("lvl8_trim", ext_trim, 32'h00000FF);
    tick();
    check("done_one_cycle", done, 0);

    // 4. Release from 8: dco held through ramp, cleared with done
    run_req(1'b0, 8, 8, 0, 1'b0, 0);
    check("release_trim", ext_trim, 0);

    // 3. Code 31 clamps to 26
    run_req(1'b1, 31, 0, 26, 1'b0, 0);
    check("clamp_trim", ext_trim, 32'h3FFFFFF);
    run_req(1'b0, 0, 26, 0, 1'b0, 0);

    // 5. Request held during ramp with a different code; taken right after done
    run_req(1'b1, 3, 0, 3, 1'b1, 10);
    run_req(1'b1, 10, 3, 10, 1'b0, 0);
    run_req(1'b0, 0, 10, 0, 1'b0, 0);

    // 6. Async reset mid-ramp at level 5
    req_valid = 1'b1;
    req_code  = 5'd20;
    req_mode  = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (5 * STEP) tick();
    check("pre_rst_level", level, 5);
    repeat (3) tick();
    #4 resetb = 1'b0;
    #1;
    check("abort_level", level, 0);
    check("abort_trim", ext_trim, 0);
    check("abort_dco", dco, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (2) tick();
    check("abort_no_done", done, 0);
    #3 resetb = 1'b1;
    exp_dco = 1'b0;
    tick();
    check("abort_ready", req_ready, 1);
    $display("txn abort: level=%0d dco=%0d", level, dco);
    run_req(1'b1, 0, 0, 0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
